// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer: hold-state
// encoding and the bit-counter width helper.
package sipo_deserializer_pkg;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_e;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_deserializer_hold_reg.sv
// One-entry valid/ready holding register. A load arriving while full and not
// being drained is dropped and sets the sticky overrun flag.
module sipo_hold_reg
    import sipo_deserializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word_in,
    input  logic             ready,
    output logic [WIDTH-1:0] word_out,
    output logic             valid,
    output logic             overrun,
    output hold_state_e      state
);

    hold_state_e      state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        overrun_d = overrun_q;
        case (state_q)
            HOLD_EMPTY: begin
                if (load) begin
                    state_d = HOLD_FULL;
                    word_d  = word_in;
                end
            end
            HOLD_FULL: begin
                // Drain and refill on the same edge keeps the register full with no bubble.
                if (load) begin
                    if (ready) begin
                        word_d = word_in;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (ready) begin
                    state_d = HOLD_EMPTY;
                end
            end
            default: state_d = HOLD_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HOLD_EMPTY;
            word_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            overrun_q <= overrun_d;
        end
    end

    assign word_out = word_q;
    assign valid    = (state_q == HOLD_FULL);
    assign overrun  = overrun_q;
    assign state    = state_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Assembles WIDTH-bit words from a qualified serial bit stream and hands them
// to a one-entry valid/ready holding register.
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     d,
    input  logic                     d_en,
    output logic [WIDTH-1:0]         q_word,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic                     overrun,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shifted;
    logic             complete;
    hold_state_e      hold_state;

    always_comb begin
        if (MSB_FIRST) begin
            shifted = {sh_q[WIDTH-2:0], d};
        end else begin
            shifted = {d, sh_q[WIDTH-1:1]};
        end
        complete = d_en && (cnt_q == CNT_LAST);
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        if (d_en) begin
            sh_d  = shifted;
            cnt_d = complete ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    // The completing word includes the bit sampled on this edge, so the
    // holding register loads the freshly shifted value, not sh_q.
    sipo_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (complete),
        .word_in  (shifted),
        .ready    (q_ready),
        .word_out (q_word),
        .valid    (q_valid),
        .overrun  (overrun),
        .state    (hold_state)
    );

    assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: an MSB-first and an LSB-first instance
// share stimulus; expected words are queued when sent and popped on completion.
module tb_sipo_deserializer;

    logic       clk;
    logic       rst;
    logic       d;
    logic       d_en;
    logic       q_ready;
    logic [7:0] q_word_m, q_word_l;
    logic       q_valid_m, q_valid_l;
    logic       overrun_m, overrun_l;
    logic [2:0] bit_cnt_m, bit_cnt_l;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];
    logic [7:0] last_m = 8'h00;
    logic [7:0] last_l = 8'h00;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .d_en    (d_en),
        .q_word  (q_word_m),
        .q_valid (q_valid_m),
        .q_ready (q_ready),
        .overrun (overrun_m),
        .bit_cnt (bit_cnt_m)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .d_en    (d_en),
        .q_word  (q_word_l),
        .q_valid (q_valid_l),
        .q_ready (q_ready),
        .overrun (overrun_l),
        .bit_cnt (bit_cnt_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            d    = 1'($urandom_range(0, 1));
            d_en = 1'($urandom_range(0, 1));
            tick();
        end
        rst  = 1'b0;
        d_en = 1'b0;
    endtask

    // Bits go out w[7] first. The MSB-first instance should rebuild w, the
    // LSB-first instance its bit reversal.
    task automatic send_word(input logic [7:0] w, input bit gap, input logic rdy,
                             input logic rdy_last, input bit loads);
        if (loads) begin
            exp_q.push_back(w);
            exp2_q.push_back(rev8(w));
        end
        for (int i = 0; i < 8; i++) begin
            d       = w[7-i];
            d_en    = 1'b1;
            q_ready = (i == 7) ? rdy_last : rdy;
            tick();
            if (i < 7) begin
                chk("bit_cnt", 32'(bit_cnt_m), 32'(i + 1));
                if (gap) begin
                    d    = 1'($urandom_range(0, 1));
                    d_en = 1'b0;
                    tick();
                    chk("bit_cnt_gap", 32'(bit_cnt_m), 32'(i + 1));
                end
            end
        end
        d_en = 1'b0;
        chk("bit_cnt_wrap", 32'(bit_cnt_m), 32'd0);
        chk("q_valid_done", 32'(q_valid_m), 32'd1);
        if (loads) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0 && exp2_q.size() != 0), 32'd1);
            if (exp_q.size() != 0 && exp2_q.size() != 0) begin
                last_m = exp_q.pop_front();
                last_l = exp2_q.pop_front();
            end
        end
        chk("q_word_msb", 32'(q_word_m), 32'(last_m));
        chk("q_word_lsb", 32'(q_word_l), 32'(last_l));
    endtask

    initial begin
        rst = 1'b0; d = 1'b0; d_en = 1'b0; q_ready = 1'b0;

        // Reset
        do_reset(2);
        chk("rst_q_word", 32'(q_word_m), 32'h00);
        chk("rst_q_valid", 32'(q_valid_m), 32'd0);
        chk("rst_overrun", 32'(overrun_m), 32'd0);
        chk("rst_bit_cnt", 32'(bit_cnt_m), 32'd0);
        chk("rst_q_valid_lsb", 32'(q_valid_l), 32'd0);
        last_m = 8'h00; last_l = 8'h00;

        // Basic word, then drained the next cycle
        send_word(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
        q_ready = 1'b1;
        tick();
        chk("basic_drained", 32'(q_valid_m), 32'd0);
        chk("basic_word_kept", 32'(q_word_m), 32'hA5);

        // Gaps and bit order
        send_word(8'h80, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("order_msb_80", 32'(q_word_m), 32'h80);
        chk("order_lsb_01", 32'(q_word_l), 32'h01);
        tick();
        chk("gap_drained", 32'(q_valid_m), 32'd0);

        // Back-pressure and overrun
        send_word(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_no_overrun_yet", 32'(overrun_m), 32'd0);
        send_word(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_overrun", 32'(overrun_m), 32'd1);
        chk("bp_word_held", 32'(q_word_m), 32'hA5);
        q_ready = 1'b1;
        tick();
        q_ready = 1'b0;
        chk("bp_drained", 32'(q_valid_m), 32'd0);
        chk("bp_overrun_sticky", 32'(overrun_m), 32'd1);
        tick();
        chk("bp_overrun_sticky2", 32'(overrun_m), 32'd1);

        // Simultaneous drain and complete
        do_reset(1);
        last_m = 8'h00; last_l = 8'h00;
        chk("sim_rst_overrun", 32'(overrun_m), 32'd0);
        send_word(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("sim_word_3c", 32'(q_word_m), 32'h3C);
        chk("sim_no_overrun", 32'(overrun_m), 32'd0);
        q_ready = 1'b1;
        tick();
        chk("sim_drained", 32'(q_valid_m), 32'd0);

        // Reset mid-word
        for (int i = 0; i < 5; i++) begin
            d = 1'b0; d_en = 1'b1;
            tick();
        end
        d_en = 1'b0;
        chk("mid_bit_cnt5", 32'(bit_cnt_m), 32'd5);
        do_reset(1);
        last_m = 8'h00; last_l = 8'h00;
        chk("mid_rst_bit_cnt", 32'(bit_cnt_m), 32'd0);
        chk("mid_rst_q_valid", 32'(q_valid_m), 32'd0);
        send_word(8'hFF, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("mid_word_ff", 32'(q_word_m), 32'hFF);

        // Random words, back-to-back and with gaps
        for (int k = 0; k < 6; k++) begin
            send_word(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1);
        end
        chk("rand_no_overrun", 32'(overrun_m), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
